// File: rtl/sfilt_pkg.sv
// Shared definitions for the serial-filter command sequencer.
// Holds the beat command codes, the sequencer FSM state encoding and the
// operand widths used by sfilt_seq and its coefficient table.
package sfilt_pkg;

    localparam int DATA_W  = 32;
    localparam int COEF_W  = 32;
    localparam int SHAMT_W = 7;

    localparam logic [1:0] CMD_FIRST = 2'd0;
    localparam logic [1:0] CMD_MAC   = 2'd1;
    localparam logic [1:0] CMD_SHIFT = 2'd2;
    localparam logic [1:0] CMD_OUT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SHIFT = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/sfilt_coef_ram.sv
// NTAPS x COEF_W coefficient register file for the filter sequencer.
// Ports:
//   clk, rst      clock, synchronous active-high clear of every entry
//   we            write enable (already qualified by the caller)
//   waddr, wdata  write index and signed coefficient
//   raddr         asynchronous read index
//   rdata         coefficient at raddr
module sfilt_coef_ram
    import sfilt_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic signed [COEF_W-1:0] mem [NTAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) mem[k] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sfilt_seq.sv
// Command sequencer feeding the serial filter. Each accepted sample is
// shifted into an NTAPS-deep delay line and produces one frame of
// NTAPS+2 beats: first-mult, NTAPS-1 mult-accumulates, shift/round, output.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pushin, din     sample valid / signed sample (one-entry hold buffer)
//   shamt           shift amount, captured when a frame starts
//   cwe, caddr,     coefficient write port, honoured only while idle
//   cdata
//   pushout, cmd,   registered beat stream toward the filter
//   q, h
//   busy            frame in progress or sample waiting in the hold
//   ovf             pulse: incoming sample dropped (hold already full)
//   cerr            pulse: coefficient write rejected
module sfilt_seq
    import sfilt_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pushin,
    input  logic [31:0]   din,
    input  logic [6:0]    shamt,
    input  logic          cwe,
    input  logic [AW-1:0] caddr,
    input  logic [31:0]   cdata,
    output logic          pushout,
    output logic [1:0]    cmd,
    output logic [31:0]   q,
    output logic [31:0]   h,
    output logic          busy,
    output logic          ovf,
    output logic          cerr
);

    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
    localparam logic [AW:0]   NTAPS_W  = (AW+1)'(NTAPS);

    state_t                   state, state_nx;
    logic [AW-1:0]            tap, tap_nx;
    logic                     pushout_nx;
    logic [1:0]               cmd_nx;
    logic [31:0]              q_nx, h_nx;
    logic                     start;

    logic signed [DATA_W-1:0] x [NTAPS];
    logic signed [DATA_W-1:0] hold;
    logic                     hold_vld;
    logic [SHAMT_W-1:0]       shamt_r;
    logic [31:0]              coef_rd;
    logic                     cwr_bad;
    logic                     cwr_ok;

    assign busy    = (state != IDLE) || hold_vld;
    // The table is frozen from the moment a held sample is pending, so a
    // frame always sees one consistent coefficient set.
    assign cwr_bad = cwe && (busy || ({1'b0, caddr} >= NTAPS_W));
    assign cwr_ok  = cwe && !cwr_bad;

    sfilt_coef_ram #(
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_coef (
        .clk   (clk),
        .rst   (rst),
        .we    (cwr_ok),
        .waddr (caddr),
        .wdata (cdata),
        .raddr (tap),
        .rdata (coef_rd)
    );

    always_comb begin
        state_nx   = state;
        tap_nx     = tap;
        pushout_nx = 1'b0;
        cmd_nx     = cmd;
        q_nx       = q;
        h_nx       = h;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (hold_vld) begin
                    start    = 1'b1;
                    tap_nx   = '0;
                    state_nx = MAC;
                end
            end
            MAC: begin
                pushout_nx = 1'b1;
                cmd_nx     = (tap == '0) ? CMD_FIRST : CMD_MAC;
                q_nx       = x[tap];
                h_nx       = coef_rd;
                if (tap == LAST_TAP) begin
                    tap_nx   = '0;
                    state_nx = SHIFT;
                end else begin
                    tap_nx = tap + 1'b1;
                end
            end
            SHIFT: begin
                pushout_nx = 1'b1;
                cmd_nx     = CMD_SHIFT;
                q_nx       = '0;
                h_nx       = {{(32-SHAMT_W){1'b0}}, shamt_r};
                state_nx   = FLUSH;
            end
            FLUSH: begin
                pushout_nx = 1'b1;
                cmd_nx     = CMD_OUT;
                q_nx       = '0;
                h_nx       = '0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control state and registered beat outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tap     <= '0;
            pushout <= 1'b0;
            cmd     <= CMD_FIRST;
            q       <= '0;
            h       <= '0;
        end else begin
            state   <= state_nx;
            tap     <= tap_nx;
            pushout <= pushout_nx;
            cmd     <= cmd_nx;
            q       <= q_nx;
            h       <= h_nx;
        end
    end

    // Hold buffer, delay line and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold     <= '0;
            shamt_r  <= '0;
            ovf      <= 1'b0;
            cerr     <= 1'b0;
            for (int k = 0; k < NTAPS; k++) x[k] <= '0;
        end else begin
            cerr <= cwr_bad;
            // A sample arriving on the edge that empties the hold refills it.
            ovf  <= pushin && hold_vld && !start;
            if (start) begin
                x[0] <= hold;
                for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
                shamt_r <= shamt;
            end
            if (pushin && (!hold_vld || start)) begin
                hold     <= din;
                hold_vld <= 1'b1;
            end else if (start) begin
                hold_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sfilt_seq.sv
// Directed bench for sfilt_seq (NTAPS=8): frame contents and timing,
// hold/overflow behaviour, coefficient write protection, shift field and
// mid-frame reset.
module tb_sfilt_seq;

    localparam int NT  = 8;
    localparam int AWT = 3;
    localparam int FL  = NT + 2;

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic           pushin = 1'b0;
    logic [31:0]    din    = '0;
    logic [6:0]     shamt  = '0;
    logic           cwe    = 1'b0;
    logic [AWT-1:0] caddr  = '0;
    logic [31:0]    cdata  = '0;
    logic           pushout;
    logic [1:0]     cmd;
    logic [31:0]    q;
    logic [31:0]    h;
    logic           busy;
    logic           ovf;
    logic           cerr;

    sfilt_seq #(.NTAPS(NT)) dut (
        .clk     (clk),
        .rst     (rst),
        .pushin  (pushin),
        .din     (din),
        .shamt   (shamt),
        .cwe     (cwe),
        .caddr   (caddr),
        .cdata   (cdata),
        .pushout (pushout),
        .cmd     (cmd),
        .q       (q),
        .h       (h),
        .busy    (busy),
        .ovf     (ovf),
        .cerr    (cerr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc      = 0;
    int ovf_cnt  = 0;
    int cerr_cnt = 0;

    logic [1:0]  b_cmd [$];
    logic [31:0] b_q   [$];
    logic [31:0] b_h   [$];
    int          b_cyc [$];

    logic [1:0]  e_cmd [$];
    logic [31:0] e_q   [$];
    logic [31:0] e_h   [$];

    int xm [NT];
    int cm [NT];

    // Beat collector: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pushout === 1'b1) begin
                b_cmd.push_back(cmd);
                b_q.push_back(q);
                b_h.push_back(h);
                b_cyc.push_back(cyc);
            end
            if (ovf === 1'b1) ovf_cnt++;
            if (cerr === 1'b1) cerr_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_all();
        b_cmd.delete(); b_q.delete(); b_h.delete(); b_cyc.delete();
        e_cmd.delete(); e_q.delete(); e_h.delete();
    endtask

    // Expected frame for an accepted sample, using the current shamt input.
    task automatic model_push(input int v);
        for (int k = NT - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = v;
        for (int i = 0; i < FL; i++) begin
            e_cmd.push_back(i == 0 ? 2'd0 : (i < NT ? 2'd1 : (i == NT ? 2'd2 : 2'd3)));
            e_q.push_back(i < NT ? 32'(xm[i]) : 32'd0);
            e_h.push_back(i < NT ? 32'(cm[i]) : (i == NT ? 32'(shamt) : 32'd0));
        end
    endtask

    task automatic push(input int v, output int at);
        pushin = 1'b1;
        din    = 32'(v);
        step();
        pushin = 1'b0;
        at     = cyc;
        model_push(v);
    endtask

    task automatic write_coef(input int a, input int v, input bit accepted);
        cwe   = 1'b1;
        caddr = AWT'(a);
        cdata = 32'(v);
        step();
        cwe   = 1'b0;
        if (accepted) cm[a] = v;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k;
        k = 0;
        while (b_cmd.size() < n && k < 80) begin
            step();
            k++;
        end
        check_eq({tag, "_arrive"}, 32'(b_cmd.size() >= n), 32'd1);
    endtask

    task automatic check_frames(input string tag);
        int n;
        check_eq({tag, "_nbeats"}, 32'(b_cmd.size()), 32'(e_cmd.size()));
        n = (b_cmd.size() < e_cmd.size()) ? b_cmd.size() : e_cmd.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_cmd%0d", tag, i), 32'(b_cmd[i]), 32'(e_cmd[i]));
            check_eq($sformatf("%s_q%0d", tag, i), b_q[i], e_q[i]);
            check_eq($sformatf("%s_h%0d", tag, i), b_h[i], e_h[i]);
            if ((i % FL) != 0)
                check_eq($sformatf("%s_contig%0d", tag, i), 32'(b_cyc[i]), 32'(b_cyc[i - (i % FL)] + (i % FL)));
        end
        clear_all();
    endtask

    function automatic longint z_of(input int off);
        longint s;
        s = 0;
        for (int i = 0; i < NT; i++)
            s += longint'(signed'(b_q[off+i])) * longint'(signed'(b_h[off+i]));
        return s >>> b_h[off+NT];
    endfunction

    initial begin
        int at;
        int o0;
        int c0;

        for (int k = 0; k < NT; k++) begin xm[k] = 0; cm[k] = 0; end

        // Reset state
        step();
        step();
        check_eq("rst_pushout", 32'(pushout), 32'd0);
        check_eq("rst_cmd", 32'(cmd), 32'd0);
        check_eq("rst_q", q, 32'd0);
        check_eq("rst_h", h, 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_cerr", 32'(cerr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Test 1: c[k]=k+1, single sample 5
        c0 = cerr_cnt;
        for (int k = 0; k < NT; k++) write_coef(k, k + 1, 1'b1);
        check_eq("t1_cerr_idle", 32'(cerr_cnt - c0), 32'd0);
        clear_all();
        shamt = 7'd0;
        push(5, at);
        wait_beats("t1", FL);
        repeat (3) step();
        check_eq("t1_latency", 32'(b_cyc[0] - at), 32'd2);
        check_eq("t1_q0", b_q[0], 32'd5);
        check_eq("t1_h7", b_h[7], 32'd8);
        check_frames("t1");

        // Test 2: second sample 7 -> z = 7*1 + 5*2
        push(7, at);
        wait_beats("t2", FL);
        repeat (3) step();
        check_eq("t2_q1", b_q[1], 32'd5);
        check_eq("t2_z", 32'(z_of(0)), 32'd17);
        check_frames("t2");

        // Test 3: three consecutive pushes; third one dropped
        o0 = ovf_cnt;
        pushin = 1'b1;
        din = 32'd1; step(); at = cyc; model_push(1);
        din = 32'd2; step(); model_push(2);
        din = 32'd3; step();
        pushin = 1'b0;
        wait_beats("t3", 2 * FL);
        repeat (3) step();
        check_eq("t3_ovf", 32'(ovf_cnt - o0), 32'd1);
        check_eq("t3_latency", 32'(b_cyc[0] - at), 32'd2);
        check_eq("t3_gap", 32'(b_cyc[FL] - b_cyc[FL-1]), 32'd2);
        check_eq("t3_f2_q0", b_q[FL], 32'd2);
        check_frames("t3");

        // Test 4: coefficient write during a frame is rejected
        c0 = cerr_cnt;
        push(4, at);
        wait_beats("t4a_first", 1);
        write_coef(0, 99, 1'b0);
        check_eq("t4_cerr_busy", 32'(cerr_cnt - c0), 32'd1);
        wait_beats("t4a", FL);
        repeat (3) step();
        check_eq("t4a_h0", b_h[0], 32'd1);
        check_frames("t4a");
        write_coef(0, 99, 1'b1);
        check_eq("t4_cerr_idle", 32'(cerr_cnt - c0), 32'd1);
        push(6, at);
        wait_beats("t4b", FL);
        repeat (3) step();
        check_eq("t4b_h0", b_h[0], 32'd99);
        check_frames("t4b");

        // Test 5: cleared delay line, c[k]=8, shamt=3, sample 1
        rst = 1'b1; step(); rst = 1'b0;
        clear_all();
        for (int k = 0; k < NT; k++) begin xm[k] = 0; cm[k] = 0; end
        for (int k = 0; k < NT; k++) write_coef(k, 8, 1'b1);
        shamt = 7'd3;
        push(1, at);
        wait_beats("t5_first", 1);
        shamt = 7'd5;
        wait_beats("t5", FL);
        repeat (3) step();
        check_eq("t5_shift_h", b_h[NT], 32'd3);
        check_eq("t5_z", 32'(z_of(0)), 32'd1);
        check_frames("t5");

        // Test 6: reset on the 4th beat
        shamt = 7'd0;
        push(9, at);
        wait_beats("t6_beat4", 4);
        rst = 1'b1; step(); rst = 1'b0;
        check_eq("t6_pushout", 32'(pushout), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check_eq("t6_no_resume", 32'(b_cmd.size()), 32'd4);
        clear_all();
        for (int k = 0; k < NT; k++) begin xm[k] = 0; cm[k] = 0; end
        push(11, at);
        wait_beats("t6", FL);
        repeat (3) step();
        check_eq("t6_q0", b_q[0], 32'd11);
        check_eq("t6_q1", b_q[1], 32'd0);
        check_eq("t6_q7", b_q[7], 32'd0);
        check_frames("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
